// File: rtl/munky_pkg.sv
// rtl/munky_pkg.sv - shared types and helpers for the register-file write-back path
package munky_pkg;
    localparam int XLEN     = 64;
    localparam int IDX_W    = 6;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

    typedef struct packed {
        logic [IDX_W-1:0] Reg;
        logic [XLEN-1:0]  Data;
    } wb_entry_t;

    // Writes to the zero register or to an out-of-range index are swallowed.
    function automatic logic is_discarded(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(ZERO_REG)) || idx[IDX_W-1];
    endfunction

    // Out-of-range indices shift the bit off the top, giving an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO of write-back entries with a per-entry register view
module wb_fifo
    import munky_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              push_entry,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t              head,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH*IDX_W-1:0] entry_reg
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t       store [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) store[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] offset;
        assign offset                         = PW'(i) - rd_ptr;
        assign entry_valid[i]                 = ({1'b0, offset} < count);
        assign entry_reg[i*IDX_W +: IDX_W]    = store[i].Reg;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges ALU and load write-backs onto the single register-file write port
module regfile_write_arbiter #(
    parameter int XLEN  = munky_pkg::XLEN,
    parameter int IDX_W = munky_pkg::IDX_W,
    parameter int DEPTH = 2
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          AluValid,
    output logic                          AluReady,
    input  logic [IDX_W-1:0]              AluReg,
    input  logic [XLEN-1:0]               AluData,
    input  logic                          MemValid,
    output logic                          MemReady,
    input  logic [IDX_W-1:0]              MemReg,
    input  logic [XLEN-1:0]               MemData,
    output logic                          RegWrite,
    output logic [IDX_W-1:0]              WriteReg,
    output logic [XLEN-1:0]               WriteData,
    output logic [munky_pkg::NUM_REGS-1:0] Pending
);
    import munky_pkg::*;

    wb_entry_t              alu_in, mem_in, alu_head, mem_head, win;
    logic                   alu_full, alu_empty, mem_full, mem_empty;
    logic                   alu_push, mem_push, alu_pop, mem_pop;
    logic [DEPTH-1:0]       alu_valid_v, mem_valid_v;
    logic [DEPTH*IDX_W-1:0] alu_reg_v, mem_reg_v;
    grant_t                 last_grant, grant_src;
    logic                   grant_valid;

    assign AluReady = RSTn && !alu_full;
    assign MemReady = RSTn && !mem_full;
    assign alu_push = AluValid && AluReady && !is_discarded(AluReg);
    assign mem_push = MemValid && MemReady && !is_discarded(MemReg);
    assign alu_in   = '{Reg: AluReg, Data: AluData};
    assign mem_in   = '{Reg: MemReg, Data: MemData};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .CLK(CLK), .RSTn(RSTn), .push(alu_push), .pop(alu_pop), .push_entry(alu_in),
        .full(alu_full), .empty(alu_empty), .head(alu_head),
        .entry_valid(alu_valid_v), .entry_reg(alu_reg_v)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .CLK(CLK), .RSTn(RSTn), .push(mem_push), .pop(mem_pop), .push_entry(mem_in),
        .full(mem_full), .empty(mem_empty), .head(mem_head),
        .entry_valid(mem_valid_v), .entry_reg(mem_reg_v)
    );

    // Same-target heads go to MEM: the load belongs to the older instruction.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = GRANT_ALU;
        if (!alu_empty && !mem_empty) begin
            grant_valid = 1'b1;
            if ((alu_head.Reg == mem_head.Reg) || (last_grant == GRANT_ALU))
                grant_src = GRANT_MEM;
        end else if (!mem_empty) begin
            grant_valid = 1'b1;
            grant_src   = GRANT_MEM;
        end else if (!alu_empty) begin
            grant_valid = 1'b1;
        end
    end

    assign alu_pop = grant_valid && (grant_src == GRANT_ALU);
    assign mem_pop = grant_valid && (grant_src == GRANT_MEM);
    assign win     = (grant_src == GRANT_MEM) ? mem_head : alu_head;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            RegWrite   <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
            last_grant <= GRANT_ALU;
        end else begin
            RegWrite <= grant_valid;
            if (grant_valid) begin
                WriteReg   <= win.Reg;
                WriteData  <= win.Data;
                last_grant <= grant_src;
            end
        end
    end

    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_valid_v[i]) Pending = Pending | reg_mask(alu_reg_v[i*IDX_W +: IDX_W]);
            if (mem_valid_v[i]) Pending = Pending | reg_mask(mem_reg_v[i*IDX_W +: IDX_W]);
        end
        if (RegWrite) Pending = Pending | reg_mask(WriteReg);
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        AluValid = 1'b0, MemValid = 1'b0;
    logic        AluReady, MemReady;
    logic [5:0]  AluReg = '0, MemReg = '0;
    logic [63:0] AluData = '0, MemData = '0;
    logic        RegWrite;
    logic [5:0]  WriteReg;
    logic [63:0] WriteData;
    logic [31:0] Pending;

    typedef struct {
        logic [5:0]  r;
        logic [63:0] d;
    } exp_t;

    exp_t        alu_q[$];
    exp_t        mem_q[$];
    int          src_log[$];
    logic [63:0] rf_model[32];
    logic        prev_mem_ready = 1'b1;
    int          errors = 0;
    int          checks = 0;
    logic        saw_mem_full;

    regfile_write_arbiter #(.XLEN(64), .IDX_W(6), .DEPTH(2)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .Pending(Pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on every transfer that should be buffered.
    always @(posedge CLK) begin
        if (RSTn) begin
            if (AluValid && AluReady && !(AluReg == 6'd31 || AluReg[5]))
                alu_q.push_back('{AluReg, AluData});
            if (MemValid && MemReady && !(MemReg == 6'd31 || MemReg[5]))
                mem_q.push_back('{MemReg, MemData});
        end
    end

    always @(negedge RSTn) begin
        alu_q.delete();
        mem_q.delete();
    end

    // Monitor: Pending model from the scoreboard, writes popped in per-source order.
    always @(negedge CLK) begin
        logic [31:0] exp_p;
        logic        hit;
        exp_p = '0;
        foreach (alu_q[i]) exp_p[alu_q[i].r[4:0]] = 1'b1;
        foreach (mem_q[i]) exp_p[mem_q[i].r[4:0]] = 1'b1;
        check("pending", 64'(Pending), 64'(exp_p));
        if (RegWrite) begin
            hit = 1'b0;
            if (mem_q.size() > 0 && mem_q[0].r == WriteReg && mem_q[0].d == WriteData) begin
                hit = 1'b1;
                void'(mem_q.pop_front());
                src_log.push_back(1);
                if (!prev_mem_ready) check("mem_ready_after_pop", 64'(MemReady), 64'd1);
            end else if (alu_q.size() > 0 && alu_q[0].r == WriteReg && alu_q[0].d == WriteData) begin
                hit = 1'b1;
                void'(alu_q.pop_front());
                src_log.push_back(0);
            end
            check("write_matches_scoreboard", 64'(hit), 64'd1);
            rf_model[WriteReg[4:0]] = WriteData;
        end
        prev_mem_ready = MemReady;
    end

    task automatic drive(input logic av, input logic [5:0] ar, input logic [63:0] ad,
                         input logic mv, input logic [5:0] mr, input logic [63:0] md);
        @(negedge CLK);
        #1;
        AluValid = av; AluReg = ar; AluData = ad;
        MemValid = mv; MemReg = mr; MemData = md;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((alu_q.size() + mem_q.size()) != 0 && n < 60) begin
            idle();
            n++;
        end
        check(tag, 64'(alu_q.size() + mem_q.size()), 64'd0);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        check("reset_writereg", 64'(WriteReg), 64'd0);
        check("reset_writedata", WriteData, 64'd0);
        check("reset_pending", 64'(Pending), 64'd0);
        check("reset_alu_ready", 64'(AluReady), 64'd0);
        check("reset_mem_ready", 64'(MemReady), 64'd0);
        RSTn = 1'b1;

        // Single ALU write: latency and Pending window.
        drive(1'b1, 6'd5, 64'h1234, 1'b0, 6'd0, 64'd0);
        check("t1_alu_ready", 64'(AluReady), 64'd1);
        idle();
        check("t1_no_bypass", 64'(RegWrite), 64'd0);
        check("t1_pending_buffered", 64'(Pending[5]), 64'd1);
        idle();
        check("t1_regwrite", 64'(RegWrite), 64'd1);
        check("t1_writereg", 64'(WriteReg), 64'd5);
        check("t1_writedata", WriteData, 64'h1234);
        check("t1_pending_inflight", 64'(Pending[5]), 64'd1);
        idle();
        check("t1_regwrite_clear", 64'(RegWrite), 64'd0);
        check("t1_pending_clear", 64'(Pending[5]), 64'd0);

        // Round-robin between distinct targets, MEM first after ALU grant.
        src_log.delete();
        drive(1'b1, 6'd3, 64'hA3, 1'b1, 6'd7, 64'hB7);
        drive(1'b1, 6'd4, 64'hA4, 1'b1, 6'd8, 64'hB8);
        check("t2_both_ready", 64'(AluReady && MemReady), 64'd1);
        idle();
        drain("t2_drain");
        check("t2_count", 64'(src_log.size()), 64'd4);
        if (src_log.size() == 4) begin
            check("t2_order0_mem", 64'(src_log[0]), 64'd1);
            check("t2_order1_alu", 64'(src_log[1]), 64'd0);
            check("t2_order2_mem", 64'(src_log[2]), 64'd1);
            check("t2_order3_alu", 64'(src_log[3]), 64'd0);
        end

        // Same target: the load retires first, ALU value is final.
        src_log.delete();
        drive(1'b1, 6'd9, 64'hAAAA, 1'b1, 6'd9, 64'hBBBB);
        idle();
        drain("t3_drain");
        check("t3_count", 64'(src_log.size()), 64'd2);
        if (src_log.size() == 2) begin
            check("t3_first_mem", 64'(src_log[0]), 64'd1);
            check("t3_second_alu", 64'(src_log[1]), 64'd0);
        end
        check("t3_final_r9", rf_model[9], 64'hAAAA);

        // Saturate both sources until the MEM FIFO fills.
        saw_mem_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 6'(10 + i), 64'hA100_0000_0000_0000 | 64'(i),
                  1'b1, 6'(20 + i), 64'hB200_0000_0000_0000 | 64'(i));
            if (!MemReady) saw_mem_full = 1'b1;
        end
        idle();
        drain("t4_drain");
        check("t4_mem_ready_dropped", 64'(saw_mem_full), 64'd1);

        // Zero/out-of-range targets are accepted but never written.
        drive(1'b1, 6'd31, 64'hDEAD, 1'b0, 6'd0, 64'd0);
        check("t5_r31_ready", 64'(AluReady), 64'd1);
        drive(1'b1, 6'd40, 64'hBEEF, 1'b0, 6'd0, 64'd0);
        check("t5_r40_ready", 64'(AluReady), 64'd1);
        idle();
        idle();
        check("t5_no_regwrite", 64'(RegWrite), 64'd0);
        check("t5_no_pending", 64'(Pending), 64'd0);
        idle();
        check("t5_no_regwrite_late", 64'(RegWrite), 64'd0);

        // Asynchronous reset with writes buffered.
        drive(1'b1, 6'd11, 64'hC11, 1'b1, 6'd21, 64'hD21);
        drive(1'b1, 6'd12, 64'hC12, 1'b1, 6'd22, 64'hD22);
        drive(1'b1, 6'd13, 64'hC13, 1'b1, 6'd23, 64'hD23);
        @(posedge CLK);
        #2;
        check("t6_regwrite_before_reset", 64'(RegWrite), 64'd1);
        #1;
        RSTn = 1'b0;
        AluValid = 1'b0;
        MemValid = 1'b0;
        #1;
        check("t6_regwrite_async_drop", 64'(RegWrite), 64'd0);
        check("t6_pending_async_clear", 64'(Pending), 64'd0);
        check("t6_readies_low", 64'(AluReady || MemReady), 64'd0);
        @(negedge CLK);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            check("t6_no_stale_write", 64'(RegWrite), 64'd0);
        end
        check("t6_pending_after", 64'(Pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
